// File: rtl/rtc_multi_alarm_if.sv
// User-facing bundle of the multi-alarm real-time clock.
// master: drives clk_mode/vButton. slave: the clock core.
interface rtc_multi_alarm_if #(
    parameter int N_ALARMS = 4
);
    localparam int AW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic [1:0]          clk_mode;
    logic [3:0]          vButton;
    logic [23:0]         bcd_time;
    logic                tick_1hz;
    logic [AW-1:0]       alarm_idx;
    logic [N_ALARMS-1:0] alarm_en;
    logic                buzzer;
    logic [AW-1:0]       ring_idx;

    modport master (
        output clk_mode, vButton,
        input  bcd_time, tick_1hz, alarm_idx,
        input  alarm_en, buzzer, ring_idx
    );

    modport slave (
        input  clk_mode, vButton,
        output bcd_time, tick_1hz, alarm_idx,
        output alarm_en, buzzer, ring_idx
    );
endinterface

// File: rtl/rtc_multi_alarm.sv
// BCD real-time clock with N alarms, ring/snooze FSM and set modes.
// Ports: mclk, rst (async active-low), bus (clk_mode, vButton in; time/alarm status out).
module rtc_multi_alarm #(
    parameter int M_FREQ     = 20000000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SECS  = 5,
    parameter int SNOOZE_MIN = 5
) (
    input  logic               mclk,
    input  logic               rst,
    rtc_multi_alarm_if.slave   bus
);
    localparam int AW  = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int PW  = (M_FREQ > 1) ? $clog2(M_FREQ) : 1;
    localparam int SNZ = SNOOZE_MIN * 60;
    localparam int RW  = $clog2(RING_SECS + 2);
    localparam int SW  = $clog2(SNZ + 2);

    localparam logic [PW-1:0] P_MAX  = PW'(M_FREQ - 1);
    localparam logic [RW-1:0] R_LOAD = RW'(RING_SECS);
    localparam logic [SW-1:0] S_LOAD = SW'(SNZ);
    localparam logic [AW-1:0] A_LAST = AW'(N_ALARMS - 1);

    typedef enum logic [1:0] {IDLE, RING, SNOOZE} state_t;

    function automatic logic [7:0] inc_bcd(input logic [7:0] v,
                                           input logic [7:0] top);
        if (v == top)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    logic [PW-1:0]       presc;
    logic [7:0]          hh, mm, ss;
    logic [7:0]          al_hh [N_ALARMS];
    logic [7:0]          al_mm [N_ALARMS];
    logic [N_ALARMS-1:0] al_en;
    logic [AW-1:0]       aidx, ridx, ridx_n;
    logic [1:0]          fsel, mode_q;
    state_t              state, state_n;
    logic [RW-1:0]       ring_cnt, ring_n;
    logic [SW-1:0]       snz_cnt, snz_n;

    logic       run, tick, mode_chg, hit;
    logic [3:0] b;
    logic [7:0] t_hh, t_mm, t_ss;
    logic [AW-1:0] hit_idx;

    assign b        = bus.vButton;
    assign run      = (bus.clk_mode == 2'd0) || (bus.clk_mode == 2'd3);
    assign mode_chg = (bus.clk_mode != mode_q);
    // gated by rst so a degenerate M_FREQ=1 cannot tick during reset
    assign tick     = rst && run && (presc == P_MAX);

    // time after this tick's increment; alarms compare against it
    assign t_ss = inc_bcd(ss, 8'h59);
    assign t_mm = (ss == 8'h59) ? inc_bcd(mm, 8'h59) : mm;
    assign t_hh = (ss == 8'h59 && mm == 8'h59) ? inc_bcd(hh, 8'h23) : hh;

    // descending scan so the lowest matching index is left in hit_idx
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (al_en[i] && al_hh[i] == t_hh && al_mm[i] == t_mm) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
        if (!tick || t_ss != 8'h00)
            hit = 1'b0;
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            hh     <= '0;
            mm     <= '0;
            ss     <= '0;
            al_en  <= '0;
            aidx   <= '0;
            fsel   <= '0;
            mode_q <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                al_hh[i] <= '0;
                al_mm[i] <= '0;
            end
        end else begin
            mode_q <= bus.clk_mode;

            if (!run || tick)
                presc <= '0;
            else
                presc <= presc + 1'b1;

            if (tick) begin
                hh <= t_hh;
                mm <= t_mm;
                ss <= t_ss;
            end

            if (mode_chg)
                fsel <= '0;
            else if (!run && b[1])
                fsel <= (fsel == 2'd2) ? 2'd0 : fsel + 2'd1;

            if (bus.clk_mode == 2'd1 && b[0]) begin
                case (fsel)
                    2'd0:    ss <= inc_bcd(ss, 8'h59);
                    2'd1:    mm <= inc_bcd(mm, 8'h59);
                    default: hh <= inc_bcd(hh, 8'h23);
                endcase
            end

            // alarms carry no seconds, so field 0 edits minutes too
            if (bus.clk_mode == 2'd2) begin
                if (b[0]) begin
                    if (fsel == 2'd2)
                        al_hh[aidx] <= inc_bcd(al_hh[aidx], 8'h23);
                    else
                        al_mm[aidx] <= inc_bcd(al_mm[aidx], 8'h59);
                end
                if (b[3])
                    al_en[aidx] <= ~al_en[aidx];
                if (b[2])
                    aidx <= (aidx == A_LAST) ? '0 : aidx + 1'b1;
            end
        end
    end

    always_ff @(posedge mclk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ring_cnt <= '0;
            snz_cnt  <= '0;
            ridx     <= '0;
        end else begin
            state    <= state_n;
            ring_cnt <= ring_n;
            snz_cnt  <= snz_n;
            ridx     <= ridx_n;
        end
    end

    // buttons are tested before counter expiry so they win a tie
    always_comb begin
        state_n = state;
        ring_n  = ring_cnt;
        snz_n   = snz_cnt;
        ridx_n  = ridx;
        if (!run) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (hit) begin
                        state_n = RING;
                        ring_n  = R_LOAD;
                        ridx_n  = hit_idx;
                    end
                end
                RING: begin
                    if (b[2]) begin
                        state_n = IDLE;
                    end else if (b[3]) begin
                        state_n = SNOOZE;
                        snz_n   = S_LOAD;
                    end else if (tick) begin
                        ring_n = (ring_cnt != '0) ? ring_cnt - 1'b1 : '0;
                        if (ring_cnt <= RW'(1))
                            state_n = IDLE;
                    end
                end
                SNOOZE: begin
                    if (b[2]) begin
                        state_n = IDLE;
                    end else if (tick) begin
                        snz_n = (snz_cnt != '0) ? snz_cnt - 1'b1 : '0;
                        if (snz_cnt <= SW'(1)) begin
                            state_n = RING;
                            ring_n  = R_LOAD;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign bus.bcd_time  = run && bus.clk_mode == 2'd0 ? {hh, mm, ss}
                         : bus.clk_mode == 2'd1       ? {hh, mm, ss}
                         : {al_hh[aidx], al_mm[aidx], 8'h00};
    assign bus.tick_1hz  = tick;
    assign bus.alarm_idx = aidx;
    assign bus.alarm_en  = al_en;
    assign bus.buzzer    = (state == RING);
    assign bus.ring_idx  = ridx;
endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed bench for rtc_multi_alarm with a queue-based scoreboard.
// Runs M_FREQ=4, N_ALARMS=4, RING_SECS=5, SNOOZE_MIN=1.
module tb_rtc_multi_alarm;
    localparam int NA = 4;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    logic mclk = 1'b0;
    logic rst  = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   hits;
    sb_t  sbq[$];

    rtc_multi_alarm_if #(.N_ALARMS(NA)) bus ();

    rtc_multi_alarm #(
        .M_FREQ(4), .N_ALARMS(NA), .RING_SECS(5), .SNOOZE_MIN(1)
    ) dut (
        .mclk(mclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 mclk = ~mclk;

    task automatic expect_v(input string tag, input logic [31:0] e);
        sb_t s;
        s.tag = tag;
        s.exp = e;
        sbq.push_back(s);
    endtask

    task automatic check(input logic [31:0] obs);
        sb_t s;
        n_chk++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %0h with no expected entry", obs);
        end else begin
            s = sbq.pop_front();
            assert (obs === s.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", s.tag, obs, s.exp);
            end
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] e,
                       input logic [31:0] obs);
        expect_v(tag, e);
        check(obs);
    endtask

    task automatic step();
        @(negedge mclk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target)
            step();
    endtask

    task automatic press(input logic [3:0] b);
        bus.vButton = b;
        step();
        bus.vButton = 4'd0;
    endtask

    task automatic presses(input logic [3:0] b, input int n);
        repeat (n) press(b);
    endtask

    initial begin
        bus.clk_mode = 2'd0;
        bus.vButton  = 4'd0;
        repeat (3) @(negedge mclk);
        cmp("rst_bcd",      32'h0, bus.bcd_time);
        cmp("rst_tick",     32'h0, bus.tick_1hz);
        cmp("rst_buzzer",   32'h0, bus.buzzer);
        cmp("rst_alarm_en", 32'h0, bus.alarm_en);
        cmp("rst_ring_idx", 32'h0, bus.ring_idx);
        rst = 1'b1;
        step();

        // set 23:59:58, then run across midnight
        bus.clk_mode = 2'd1;
        step();
        presses(4'b0001, 58);
        press(4'b0010);
        presses(4'b0001, 59);
        press(4'b0010);
        presses(4'b0001, 23);
        cmp("set_235958", 32'h235958, bus.bcd_time);
        hits = 0;
        repeat (8) begin
            hits += int'(bus.tick_1hz);
            step();
        end
        cmp("mode1_no_tick", 32'h0, hits);

        bus.clk_mode = 2'd0;
        cyc = 0;
        for (int k = 1; k <= 8; k++)
            expect_v($sformatf("tick_c%0d", k), (k % 4 == 0) ? 32'h1 : 32'h0);
        for (int k = 1; k <= 8; k++) begin
            #1;
            check(bus.tick_1hz);
            step();
        end
        cmp("wrap_midnight", 32'h000000, bus.bcd_time);

        // alarm 1 = 00:01 enabled
        bus.clk_mode = 2'd2;
        step();
        press(4'b0100);
        press(4'b0001);
        press(4'b1000);
        cmp("alarm_idx1", 32'h1, bus.alarm_idx);
        cmp("mode2_bcd", 32'h000100, bus.bcd_time);
        bus.clk_mode = 2'd3;
        #1;
        cmp("mode3_bcd", 32'h000100, bus.bcd_time);
        cmp("alarm_en_0010", 32'b0010, bus.alarm_en);
        step();

        // alarm 3 = 00:01 enabled
        bus.clk_mode = 2'd2;
        step();
        press(4'b0100);
        press(4'b0100);
        press(4'b0001);
        press(4'b1000);
        cmp("alarm_idx3", 32'h3, bus.alarm_idx);
        cmp("alarm_en_1010", 32'b1010, bus.alarm_en);
        cmp("alarm3_bcd", 32'h000100, bus.bcd_time);

        // 00:00:59, double match, lowest wins
        bus.clk_mode = 2'd1;
        step();
        presses(4'b0001, 59);
        cmp("set_000059", 32'h000059, bus.bcd_time);
        bus.clk_mode = 2'd0;
        cyc = 0;
        run_to(3);
        cmp("pre_ring", 32'h0, bus.buzzer);
        run_to(4);
        cmp("ring_rise", 32'h1, bus.buzzer);
        cmp("ring_idx", 32'h1, bus.ring_idx);
        cmp("ring_time", 32'h000100, bus.bcd_time);
        run_to(23);
        cmp("ring_hold", 32'h1, bus.buzzer);
        run_to(24);
        cmp("ring_fall", 32'h0, bus.buzzer);
        cmp("time_000105", 32'h000105, bus.bcd_time);

        // SS wrap without carry, then back to 00:00:59
        bus.clk_mode = 2'd1;
        step();
        presses(4'b0001, 54);
        cmp("ss_59", 32'h000159, bus.bcd_time);
        press(4'b0001);
        cmp("ss_wrap_no_carry", 32'h000100, bus.bcd_time);
        presses(4'b0001, 59);
        press(4'b0010);
        presses(4'b0001, 59);
        cmp("reset_000059", 32'h000059, bus.bcd_time);

        // snooze, same-cycle expiry vs snooze, dismiss in snooze
        bus.clk_mode = 2'd0;
        cyc = 0;
        run_to(4);
        cmp("ring2_rise", 32'h1, bus.buzzer);
        run_to(5);
        press(4'b1000);
        cmp("snooze_drop", 32'h0, bus.buzzer);
        run_to(243);
        cmp("snooze_hold", 32'h0, bus.buzzer);
        run_to(244);
        cmp("snooze_wake", 32'h1, bus.buzzer);
        run_to(263);
        press(4'b1000);
        cmp("expiry_vs_snooze", 32'h0, bus.buzzer);
        run_to(503);
        cmp("snooze2_hold", 32'h0, bus.buzzer);
        run_to(504);
        cmp("snooze2_wake", 32'h1, bus.buzzer);
        press(4'b1000);
        press(4'b0100);
        hits = 0;
        while (cyc < 806) begin
            hits += int'(bus.buzzer);
            step();
        end
        cmp("dismissed_quiet", 32'h0, hits);

        // 201 ticks after 00:00:59 -> 00:04:20
        bus.clk_mode = 2'd1;
        step();
        cmp("long_run_time", 32'h000420, bus.bcd_time);
        presses(4'b0001, 39);
        press(4'b0010);
        presses(4'b0001, 56);
        cmp("set3_000059", 32'h000059, bus.bcd_time);

        // reset in the middle of a ring
        bus.clk_mode = 2'd0;
        cyc = 0;
        run_to(6);
        cmp("ring3_rise", 32'h1, bus.buzzer);
        rst = 1'b0;
        #1;
        cmp("rst_async_buzzer", 32'h0, bus.buzzer);
        cmp("rst_async_tick", 32'h0, bus.tick_1hz);
        step();
        step();
        rst = 1'b1;
        step();
        #1;
        cmp("post_bcd", 32'h000000, bus.bcd_time);
        cmp("post_alarm_en", 32'h0, bus.alarm_en);
        cmp("post_alarm_idx", 32'h0, bus.alarm_idx);
        cmp("post_ring_idx", 32'h0, bus.ring_idx);
        cmp("post_buzzer", 32'h0, bus.buzzer);
        cmp("post_tick", 32'h0, bus.tick_1hz);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rtc_multi_alarm.md
RTC_MULTI_ALARM -- requirements
Module: rtc_multi_alarm

Interface
REQ-001 SHALL have parameter M_FREQ, default 20000000: mclk frequency in Hz, minimum 1.
REQ-002 SHALL have parameter N_ALARMS, default 4: number of independent alarms, range 1..16; AW = max(1, clog2(N_ALARMS)).
REQ-003 SHALL have parameter RING_SECS, default 5: buzzer duration in seconds.
REQ-004 SHALL have parameter SNOOZE_MIN, default 5: snooze length in minutes.
REQ-005 SHALL use one clock and an asynchronous active-low reset.
REQ-006 mclk  in  1: main clock; all state on rising edge.
REQ-007 rst  in  1: asynchronous active-low reset.
REQ-008 clk_mode  in  2: 0 run, 1 set time, 2 set alarm, 3 run with alarm display.
REQ-009 vButton  in  4: one-mclk pulses; [0] increment field, [1] next field, [2] next alarm / dismiss, [3] toggle enable / snooze.
REQ-010 bcd_time  out  24: HH:MM:SS, 4 bits per BCD digit, [23:20] hour tens through [3:0] second units.
REQ-011 tick_1hz  out  1: one-mclk pulse per elapsed second.
REQ-012 alarm_idx  out  AW: alarm currently selected for edit/display.
REQ-013 alarm_en  out  N_ALARMS: per-alarm enable bits.
REQ-014 buzzer  out  1: high while the ring FSM is in RING.
REQ-015 ring_idx  out  AW: index of the alarm that last triggered.

Function
REQ-016 Prescaler SHALL count 0..M_FREQ-1 in modes 0 and 3, asserting tick_1hz on the cycle it equals M_FREQ-1, then wrap to 0.
REQ-017 In modes 1 and 2 the prescaler SHALL hold at 0 and tick_1hz SHALL stay low; counting resumes from 0 on return to mode 0/3.
REQ-018 On each tick the time SHALL advance one second with BCD carry SS->MM->HH; 23:59:59 wraps to 00:00:00.
REQ-019 Field select register (0 = SS, 1 = MM, 2 = HH) SHALL advance on vButton[1] in modes 1/2 and wrap 2->0; it resets to 0 whenever clk_mode changes.
REQ-020 In mode 1, vButton[0] SHALL increment the selected time field modulo its range (SS/MM 00..59, HH 00..23) with no carry into other fields.
REQ-021 Each alarm SHALL hold HH:MM (16 bits BCD) plus one enable bit.
REQ-022 In mode 2, vButton[0] SHALL increment the selected field of alarm alarm_idx (field 0 is treated as MM), vButton[2] SHALL advance alarm_idx modulo N_ALARMS, and vButton[3] SHALL toggle alarm_en[alarm_idx].
REQ-023 bcd_time SHALL show alarm alarm_idx as HH:MM:00 in modes 2 and 3, and the clock time otherwise.
REQ-024 Alarm match SHALL be evaluated only on a tick in mode 0/3, against the post-increment time: SS = 00 and HH:MM equal to an enabled alarm.
REQ-025 On multiple simultaneous matches the lowest index SHALL win and be loaded into ring_idx.
REQ-026 Ring FSM states SHALL be IDLE, RING and SNOOZE.
REQ-027 IDLE -> RING on a match; the ring counter loads RING_SECS.
REQ-028 RING: the counter decrements on each tick; RING -> IDLE when it reaches 0.
REQ-029 RING: vButton[3] -> SNOOZE, loading the snooze counter with SNOOZE_MIN*60; vButton[2] -> IDLE.
REQ-030 SNOOZE: the counter decrements on each tick; reaching 0 -> RING with the ring counter reloaded; vButton[2] -> IDLE.
REQ-031 Matches occurring while in RING or SNOOZE SHALL be ignored.
REQ-032 A button pulse coinciding with counter expiry SHALL take priority.
REQ-033 Any entry into mode 1 or 2 SHALL force the FSM to IDLE.
REQ-034 Buttons not listed for the current mode SHALL be ignored; simultaneous pulses SHALL each apply independently.
REQ-035 Counters SHALL be sized for their full parameter ranges, with no overflow at M_FREQ = 20000000.

Reset
REQ-036 Reset assertion SHALL asynchronously clear the prescaler, the time (00:00:00), all alarms (00:00, disabled), alarm_idx, ring_idx, field select, both counters and the FSM (IDLE).
REQ-037 During reset, buzzer and tick_1hz SHALL be 0.
REQ-038 Reset asserted mid-RING SHALL drop buzzer immediately without waiting for a clock edge.

Verification (M_FREQ=4, N_ALARMS=4, RING_SECS=5, SNOOZE_MIN=1)
REQ-039 Mode 1: set 23:59:58, then mode 0 and run 8 mclk -> tick_1hz pulses on cycles 4 and 8; bcd_time = 00:00:00.
REQ-040 Mode 2: set alarm 1 = 00:01 and enable it; mode 3 -> bcd_time = 00:01:00, alarm_en = 0010.
REQ-041 Alarms 1 and 3 both = 00:01 and enabled; run from 00:00:59 -> buzzer rises on the 00:01:00 tick, ring_idx = 1, buzzer falls after 5 ticks.
REQ-042 vButton[3] during RING -> buzzer low, rises again after 60 ticks; vButton[2] in SNOOZE -> IDLE and no further ring.
REQ-043 Mode 1, field SS = 59 with vButton[0] -> SS = 00 and MM unchanged; same-cycle ring expiry and vButton[3] -> SNOOZE.
REQ-044 rst low mid-RING -> buzzer = 0 the same cycle; after release all outputs are 0 and bcd_time = 00:00:00.
